// File: rtl/deck_dealer_if.sv
// Pile-init bus between the deck dealer (master) and the talon/stock block (slave).
// Carries start/seed controls in and the dealt layout, sizes and status out.
interface deck_dealer_if #(
    parameter int CARD_SIZE   = 7,
    parameter int TALON_SLOTS = 24
);
    logic                             start;
    logic                             seed_load;
    logic [15:0]                      seed;
    logic [28*CARD_SIZE-1:0]          tableau_piles;
    logic [TALON_SLOTS*CARD_SIZE-1:0] talon_pile_init;
    logic [TALON_SLOTS*CARD_SIZE-1:0] stock_pile_init;
    logic [4:0]                       talon_size_init;
    logic [4:0]                       stock_size_init;
    logic                             setup_ready;
    logic                             busy;

    modport master (
        input  start, seed_load, seed,
        output tableau_piles, talon_pile_init, stock_pile_init,
               talon_size_init, stock_size_init, setup_ready, busy
    );

    modport slave (
        output start, seed_load, seed,
        input  tableau_piles, talon_pile_init, stock_pile_init,
               talon_size_init, stock_size_init, setup_ready, busy
    );
endinterface

// File: rtl/deck_dealer.sv
// Builds, LFSR-shuffles (Fisher-Yates) and deals a 52-card deck; 104 cycles start->ready.
// start/seed_load are ignored while busy; outputs hold in DONE until the next start.
module deck_dealer #(
    parameter int          CARD_SIZE   = 7,
    parameter int          TALON_SLOTS = 24,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    deck_dealer_if.master dif
);
    localparam int          TAB_SLOTS = 28;
    localparam logic [27:0] FACE_MASK = 28'h8104225;  // last slot of each tableau column

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_SHUFFLE, S_DEAL, S_DONE} state_t;

    state_t r_state, w_next;
    logic   w_busy;

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;
    logic [5:0]  r_idx;
    logic [5:0]  w_j;
    logic [5:0]  r_deck [52];
    logic [4:0]  w_tslot;
    logic [4:0]  w_lslot;
    logic        w_face;

    logic [TAB_SLOTS-1:0][CARD_SIZE-1:0]   r_tab;
    logic [TALON_SLOTS-1:0][CARD_SIZE-1:0] r_talon;
    logic [4:0] r_tsize;
    logic       r_ready;

    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_j        = 6'((16'(r_lfsr[7:0]) * 16'(r_idx + 6'd1)) >> 8);
    assign w_tslot    = r_idx[4:0];
    assign w_lslot    = 5'(r_idx - 6'd28);
    assign w_face     = FACE_MASK[w_tslot];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (dif.start) w_next = S_INIT;
            S_INIT: begin
                w_busy = 1'b1;
                w_next = S_SHUFFLE;
            end
            S_SHUFFLE: begin
                w_busy = 1'b1;
                if (r_idx == 6'd1) w_next = S_DEAL;
            end
            S_DEAL: begin
                w_busy = 1'b1;
                if (r_idx == 6'd51) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A seed loaded alongside start lands before SHUFFLE, so it drives that deal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
            r_idx  <= '0;
        end else begin
            if (!w_busy && dif.seed_load)
                r_lfsr <= (dif.seed == 16'h0000) ? LFSR_SEED : dif.seed;
            else if (r_state == S_SHUFFLE)
                r_lfsr <= w_lfsr_nxt;

            case (r_state)
                S_INIT:    r_idx <= 6'd51;
                S_SHUFFLE: r_idx <= (r_idx == 6'd1) ? 6'd0 : r_idx - 6'd1;
                S_DEAL:    r_idx <= r_idx + 6'd1;
                default:   r_idx <= r_idx;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            for (int k = 0; k < 52; k++)
                r_deck[k] <= {2'(k / 13), 4'(k % 13 + 1)};
        end else if (r_state == S_SHUFFLE) begin
            r_deck[r_idx] <= r_deck[w_j];
            r_deck[w_j]   <= r_deck[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tab   <= '0;
            r_talon <= '0;
            r_tsize <= '0;
            r_ready <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_tab   <= '0;
            r_talon <= '0;
            r_tsize <= '0;
            r_ready <= 1'b0;
        end else if (r_state == S_DEAL) begin
            if (r_idx < 6'd28)
                r_tab[w_tslot] <= CARD_SIZE'({w_face, r_deck[r_idx]});
            else
                r_talon[w_lslot] <= CARD_SIZE'({1'b0, r_deck[r_idx]});
            if (r_idx == 6'd51) begin
                r_tsize <= 5'(TALON_SLOTS);
                r_ready <= 1'b1;
            end
        end
    end

    assign dif.tableau_piles   = r_tab;
    assign dif.talon_pile_init = r_talon;
    assign dif.stock_pile_init = '0;
    assign dif.talon_size_init = r_tsize;
    assign dif.stock_size_init = '0;
    assign dif.setup_ready     = r_ready;
    assign dif.busy            = w_busy;
endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: directed deals plus random seeds, compared with a
// card-level Fisher-Yates reference model.
module tb_deck_dealer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    deck_dealer_if #(.CARD_SIZE(7), .TALON_SLOTS(24)) dif ();

    deck_dealer #(.CARD_SIZE(7), .TALON_SLOTS(24), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    int checks   = 0;
    int failures = 0;

    bit [15:0]  m_lfsr;
    bit [195:0] exp_tab;
    bit [167:0] exp_tal;
    bit [195:0] a_tab, d_tab;
    bit [167:0] a_tal, d_tal;

    task automatic chk(input string tag, input logic [195:0] obs, input logic [195:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shuffle a plain list of deck indices and lay the cards out as the game expects.
    task automatic model_deal();
        int deck [52];
        int j, t, face;
        for (int k = 0; k < 52; k++) deck[k] = k;
        for (int i = 51; i >= 1; i--) begin
            j = (int'(m_lfsr % 256) * (i + 1)) / 256;
            t = deck[i]; deck[i] = deck[j]; deck[j] = t;
            m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 16'h0000);
        end
        exp_tab = '0;
        exp_tal = '0;
        for (int p = 0; p < 52; p++) begin
            if (p < 28) begin
                face = 0;
                for (int c = 0; c < 7; c++)
                    if (p == c * (c + 1) / 2 + c) face = 1;
                exp_tab[p*7 +: 7] = {1'(face), 2'(deck[p] / 13), 4'(deck[p] % 13 + 1)};
            end else begin
                exp_tal[(p-28)*7 +: 7] = {1'b0, 2'(deck[p] / 13), 4'(deck[p] % 13 + 1)};
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tab"}, dif.tableau_piles, '0);
        chk({tag, "_talon"}, dif.talon_pile_init, '0);
        chk({tag, "_ready"}, dif.setup_ready, 0);
        chk({tag, "_busy"}, dif.busy, 0);
        chk({tag, "_tsize"}, dif.talon_size_init, 0);
    endtask

    task automatic check_struct(input string tag);
        int seen [52];
        int empty, bad, suit_cnt [4];
        bit [6:0] c;
        bit [27:0] face_obs, face_exp;
        bit [23:0] tface;
        empty = 0; bad = 0;
        for (int k = 0; k < 52; k++) seen[k] = 0;
        for (int s = 0; s < 4; s++) suit_cnt[s] = 0;
        for (int s = 0; s < 52; s++) begin
            c = (s < 28) ? dif.tableau_piles[s*7 +: 7] : dif.talon_pile_init[(s-28)*7 +: 7];
            if (c == 7'h00) empty++;
            else if (c[3:0] < 1 || c[3:0] > 13) bad++;
            else begin
                seen[c[5:4] * 13 + c[3:0] - 1]++;
                suit_cnt[c[5:4]]++;
            end
        end
        for (int k = 0; k < 52; k++) if (seen[k] != 1) bad++;
        for (int s = 0; s < 4; s++) if (suit_cnt[s] != 13) bad++;
        chk({tag, "_empty_slots"}, empty, 0);
        chk({tag, "_distinct_cards"}, bad, 0);
        face_exp = '0;
        for (int col = 0; col < 7; col++) face_exp[col*(col+1)/2 + col] = 1'b1;
        for (int s = 0; s < 28; s++) face_obs[s] = dif.tableau_piles[s*7 + 6];
        for (int s = 0; s < 24; s++) tface[s] = dif.talon_pile_init[s*7 + 6];
        chk({tag, "_tab_face"}, face_obs, face_exp);
        chk({tag, "_talon_face"}, tface, 0);
    endtask

    task automatic do_deal(input string tag, input bit ld, input bit [15:0] sv,
                           input int glitch_n, input int abort_n);
        int n, busy_n;
        bit done, was_done;
        @(negedge clk);
        was_done      = dif.setup_ready;
        dif.seed      = sv;
        dif.seed_load = ld;
        dif.start     = 1'b1;
        if (ld) m_lfsr = (sv == 16'h0000) ? 16'hACE1 : sv;
        model_deal();
        n = 0; busy_n = 0; done = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            dif.start = 1'b0;
            dif.seed_load = 1'b0;
            if (was_done && n == 1) chk({tag, "_ready_hold_E0"}, dif.setup_ready, 1);
            if (was_done && n == 2) chk({tag, "_ready_drop_E1"}, dif.setup_ready, 0);
            if (n == glitch_n) begin
                dif.start = 1'b1;
                dif.seed_load = 1'b1;
                dif.seed = 16'($urandom);
            end
            if (n == abort_n) begin
                rst = 1'b0;
                #1;
                check_zero({tag, "_async_rst"});
                m_lfsr = 16'hACE1;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                break;
            end
            if (dif.busy) busy_n++;
            if (dif.setup_ready && !dif.busy) done = 1;
        end
        if (n != abort_n) begin
            chk({tag, "_latency"}, n - 1, 104);
            chk({tag, "_busy_cycles"}, busy_n, 104);
            chk({tag, "_tableau"}, dif.tableau_piles, exp_tab);
            chk({tag, "_talon"}, dif.talon_pile_init, exp_tal);
            chk({tag, "_tsize"}, dif.talon_size_init, 24);
            chk({tag, "_ssize"}, dif.stock_size_init, 0);
            chk({tag, "_stock"}, dif.stock_pile_init, '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dif.start = 1'b0;
        dif.seed_load = 1'b0;
        dif.seed = '0;
        m_lfsr = 16'hACE1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset_ssize", dif.stock_size_init, 0);
        chk("reset_stock", dif.stock_pile_init, '0);

        do_deal("default", 1'b0, 16'h0000, 0, 0);
        d_tab = dif.tableau_piles;
        d_tal = dif.talon_pile_init;

        do_deal("seed1234", 1'b1, 16'h1234, 0, 0);
        check_struct("seed1234");
        a_tab = dif.tableau_piles;
        a_tal = dif.talon_pile_init;

        do_deal("seed1234b", 1'b1, 16'h1234, 0, 0);
        chk("repeat_tab", dif.tableau_piles, a_tab);
        chk("repeat_talon", dif.talon_pile_init, a_tal);

        do_deal("seed4321", 1'b1, 16'h4321, 0, 0);
        chk("seed4321_differs", (dif.tableau_piles != a_tab) || (dif.talon_pile_init != a_tal), 1);

        do_deal("seed0", 1'b1, 16'h0000, 0, 0);
        chk("seed0_eq_default_tab", dif.tableau_piles, d_tab);
        chk("seed0_eq_default_talon", dif.talon_pile_init, d_tal);

        do_deal("glitch", 1'b1, 16'h1234, 31, 0);
        chk("glitch_tab_eq_1234", dif.tableau_piles, a_tab);

        for (int r = 0; r < 3; r++) begin
            do_deal($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 16'($urandom), 0, 0);
            check_struct($sformatf("rand%0d", r));
        end

        do_deal("abort", 1'b1, 16'h5a5a, 0, 60);
        @(negedge clk);
        check_zero("post_abort");
        do_deal("after_abort", 1'b0, 16'h0000, 0, 0);
        chk("after_abort_eq_default_tab", dif.tableau_piles, d_tab);
        chk("after_abort_eq_default_talon", dif.talon_pile_init, d_tal);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
